// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned COLUMN     = 16384;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned RANGE_W    = 34;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_e;

    // Image must start word-aligned and end at or below COLUMN; 34 bits so the end never wraps.
    function automatic logic range_ok(input logic [31:0] base, input logic [15:0] cnt);
        logic [RANGE_W-1:0] end_addr;
        end_addr = {2'b00, base} + {16'b0, cnt, 2'b00};
        return (base[1:0] == 2'b00) && (end_addr <= RANGE_W'(COLUMN));
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes into a little-endian 32-bit word; byte0 lands in lane 0.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_fire_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_ready_o,
    output logic [31:0] word_o
);

    logic [1:0]                  lane_q, lane_d;
    logic [WORD_BYTES-1:0][7:0]  lanes_q, lanes_d;

    always_comb begin
        lane_d  = lane_q;
        lanes_d = lanes_q;
        if (clear_i) begin
            lane_d = 2'd0;
        end else if (byte_fire_i) begin
            lanes_d[lane_q] = byte_data_i;
            lane_d          = lane_q + 2'd1;
        end
    end

    // Pulses in the cycle the 4th byte is taken; the full word is in word_o one cycle later.
    assign word_ready_o = byte_fire_i && !clear_i && (lane_q == 2'(WORD_BYTES - 1));
    assign word_o       = lanes_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q  <= 2'd0;
            lanes_q <= '0;
        end else begin
            lane_q  <= lane_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory and holds the CPU in reset until done.
// Optional checksum byte after the image is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] word_cnt_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_wren_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        cpu_rst_o
);

    loader_state_e state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   word_idx_q, word_idx_d;
    logic          ready_q, ready_d;
    logic          wren_q, wren_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cpu_rst_q, cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    logic          start_accept;
    logic          byte_fire;
    logic          pack_fire;
    logic          word_ready;
    logic          last_word;
    logic [31:0]   packed_word;

    // A byte moves only when valid meets our registered ready.
    assign start_accept = (state_q == ST_IDLE) && start_i;
    assign byte_fire    = byte_valid_i && ready_q;
    assign pack_fire    = byte_fire && (state_q == ST_RECV);
    assign last_word    = (word_idx_q + 16'd1) == cnt_q;

    byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (start_accept),
        .byte_fire_i  (pack_fire),
        .byte_data_i  (byte_data_i),
        .word_ready_o (word_ready),
        .word_o       (packed_word)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        ready_d    = ready_q;
        wren_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        cpu_rst_d  = cpu_rst_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d     = base_addr_i;
                    cnt_d      = word_cnt_i;
                    word_idx_d = 16'd0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    // A fresh image is about to overwrite memory, so the CPU goes back into reset.
                    cpu_rst_d  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                    if (!range_ok(base_addr_i, word_cnt_i)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (word_cnt_i == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
                        ready_d = 1'b1;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_RECV;
                        ready_d = 1'b1;
                    end
                end
            end
            ST_RECV: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (pack_fire) begin
                    sum_d = sum_q + byte_data_i;
                end
`endif
                if (word_ready) begin
                    ready_d = 1'b0;
                    wren_d  = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d     = addr_q + 32'(WORD_BYTES);
                word_idx_d = word_idx_q + 16'd1;
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d   = ST_CSUM;
                    ready_d   = 1'b1;
`else
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    cpu_rst_d = err_q;
`endif
                end else begin
                    state_d = ST_RECV;
                    ready_d = 1'b1;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (byte_fire) begin
                    ready_d   = 1'b0;
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    err_d     = (byte_data_i != sum_q);
                    cpu_rst_d = (byte_data_i != sum_q);
                end
            end
`endif
            ST_DONE: begin
                // Reached directly from IDLE on error/empty image, so the result is published here too.
                busy_d    = 1'b0;
                done_d    = 1'b1;
                cpu_rst_d = err_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'd0;
            cnt_q      <= 16'd0;
            word_idx_q <= 16'd0;
            ready_q    <= 1'b0;
            wren_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            ready_q    <= ready_d;
            wren_q     <= wren_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_rst_q  <= cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign byte_ready_o = ready_q;
    assign mem_wren_o   = wren_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = packed_word;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign cpu_rst_o    = cpu_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write-queue model and a per-cycle write checker.
module tb_imem_loader;

  localparam longint COLUMN_BYTES = 16384;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = 32'd0;
  logic [15:0] word_cnt_i = 16'd0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'd0;
  logic        byte_ready_o;
  logic        mem_wren_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        cpu_rst_o;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .word_cnt_i   (word_cnt_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_wren_o   (mem_wren_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .cpu_rst_o    (cpu_rst_o)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_count = 0;
  int          edges;
  bit          wren_prev = 1'b0;
  bit          ready_seen = 1'b0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] last_wr_addr = 32'd0;
  logic [31:0] last_wr_data = 32'd0;
  logic [7:0]  stim[16];
  logic [7:0]  exp_sum = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic bit model_legal(input longint base, input longint cnt);
    return (base % 4 == 0) && (base + 4 * cnt <= COLUMN_BYTES);
  endfunction

  // Each complete group of 4 stream bytes becomes one little-endian word at base+4*w.
  task automatic push_image(input logic [31:0] base, input int nwords);
    logic [31:0] word;
    exp_sum = 8'd0;
    for (int w = 0; w < nwords; w++) begin
      word = 32'd0;
      for (int b = 0; b < 4; b++) begin
        word    = word + (32'(stim[4*w+b]) << (8 * b));
        exp_sum = exp_sum + stim[4*w+b];
      end
      exp_addr_q.push_back(base + 32'(4 * w));
      exp_data_q.push_back(word);
    end
  endtask

  task automatic set_bytes(input int off, input logic [63:0] v);
    for (int i = 0; i < 8; i++) stim[off+i] = v[63-8*i -: 8];
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (byte_ready_o) ready_seen = 1'b1;
    if (mem_wren_o) begin
      wr_count++;
      last_wr_addr = mem_addr_o;
      last_wr_data = mem_wdata_o;
      check("wren_one_cycle", 32'(wren_prev), 32'd0);
      if (exp_addr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write", mem_addr_o, mem_wdata_o);
      end else begin
        check("wr_addr", mem_addr_o, exp_addr_q.pop_front());
        check("wr_data", mem_wdata_o, exp_data_q.pop_front());
      end
    end
    wren_prev = mem_wren_o;
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},   32'(byte_ready_o), 32'd0);
    check({tag, "_wren"},    32'(mem_wren_o),   32'd0);
    check({tag, "_addr"},    mem_addr_o,        32'd0);
    check({tag, "_wdata"},   mem_wdata_o,       32'd0);
    check({tag, "_busy"},    32'(busy_o),       32'd0);
    check({tag, "_done"},    32'(done_o),       32'd0);
    check({tag, "_err"},     32'(err_o),        32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst_o),    32'd1);
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
    start_i     = 1'b1;
    base_addr_i = base;
    word_cnt_i  = cnt;
    @(posedge clk); #1;
    start_i     = 1'b0;
  endtask

  task automatic start_and_check(input string tag, input logic [31:0] base, input logic [15:0] cnt);
    do_start(base, cnt);
    @(negedge clk);
    check({tag, "_busy_t1"},  32'(busy_o),       32'd1);
    check({tag, "_ready_t1"}, 32'(byte_ready_o), 32'd1);
    check({tag, "_done_t1"},  32'(done_o),       32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_bytes(input int n, input bit toggle, output int n_edges);
    int  i;
    bit  acc;
    i = 0;
    n_edges = 0;
    while (i < n && n_edges < 300) begin
      byte_valid_i = 1'b1;
      byte_data_i  = stim[i];
      @(negedge clk);
      acc = byte_ready_o;
      @(posedge clk); #1;
      n_edges++;
      if (acc) i++;
      if (toggle && i < n) begin
        byte_valid_i = 1'b0;
        @(posedge clk); #1;
        n_edges++;
      end
    end
    byte_valid_i = 1'b0;
    check("bytes_accepted", 32'(i), 32'(n));
  endtask

  // Called right after the last data byte was taken.
  task automatic finish_check(input string tag);
    int e;
    @(negedge clk);
    check({tag, "_wren_last"}, 32'(mem_wren_o), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(posedge clk); #1;
    stim[0] = exp_sum;
    send_bytes(1, 1'b0, e);
`endif
    @(negedge clk);
    check({tag, "_done"},    32'(done_o),    32'd1);
    check({tag, "_busy"},    32'(busy_o),    32'd0);
    check({tag, "_err"},     32'(err_o),     32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst_o), 32'd0);
    @(negedge clk);
    check({tag, "_done_hold"},    32'(done_o),    32'd1);
    check({tag, "_cpu_rst_hold"}, 32'(cpu_rst_o), 32'd0);
    @(posedge clk); #1;
  endtask

  // Loads that never reach RECV: range error, or an empty image.
  task automatic no_data_check(input string tag, input logic [31:0] base, input logic [15:0] cnt);
    logic exp_err;
    exp_err    = !model_legal(64'(base), 64'(cnt));
    wr_count   = 0;
    ready_seen = 1'b0;
    do_start(base, cnt);
    @(negedge clk);
    check({tag, "_busy_t1"}, 32'(busy_o), 32'd1);
    check({tag, "_done_t1"}, 32'(done_o), 32'd0);
    check({tag, "_err_t1"},  32'(err_o),  32'(exp_err));
    @(negedge clk);
    check({tag, "_done_t2"},    32'(done_o),    32'd1);
    check({tag, "_busy_t2"},    32'(busy_o),    32'd0);
    check({tag, "_err_t2"},     32'(err_o),     32'(exp_err));
    check({tag, "_cpu_rst_t2"}, 32'(cpu_rst_o), 32'(exp_err));
    @(posedge clk); #1;
    check({tag, "_writes"},     32'(wr_count),   32'd0);
    check({tag, "_ready_seen"}, 32'(ready_seen), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Two-word image, valid held high.
    set_bytes(0, 64'h13000000_93001000);
    push_image(32'h0, 2);
    wr_count = 0;
    start_and_check("held", 32'h0, 16'd2);
    send_bytes(8, 1'b0, edges);
    check("held_cycles", 32'(edges), 32'd9);
    finish_check("held");
    check("held_writes", 32'(wr_count), 32'd2);
    check("held_last_addr", last_wr_addr, 32'h0000_0004);
    check("held_last_data", last_wr_data, 32'h0010_0093);

    // Same image, valid toggling.
    set_bytes(0, 64'h13000000_93001000);
    push_image(32'h0, 2);
    wr_count = 0;
    start_and_check("toggle", 32'h0, 16'd2);
    send_bytes(8, 1'b1, edges);
    finish_check("toggle");
    check("toggle_writes", 32'(wr_count), 32'd2);
    check("toggle_last_data", last_wr_data, 32'h0010_0093);

    // Range errors.
    no_data_check("overrun", 32'h3FFC, 16'd2);
    check("overrun_err_lit", 32'(err_o), 32'd1);
    check("overrun_cpu_rst_lit", 32'(cpu_rst_o), 32'd1);
    no_data_check("misalign", 32'h0002, 16'd1);

    // Image ending exactly at the top of memory is legal.
    set_bytes(0, 64'hDEADBEEF_BAADF00D);
    push_image(32'h3FF8, 2);
    wr_count = 0;
    start_and_check("top", 32'h3FF8, 16'd2);
    send_bytes(8, 1'b0, edges);
    finish_check("top");
    check("top_writes", 32'(wr_count), 32'd2);
    check("top_last_addr", last_wr_addr, 32'h0000_3FFC);
    check("top_last_data", last_wr_data, 32'h0DF0ADBA);

    // Reset after 6 bytes of a 3-word load: only the first word is written.
    set_bytes(0, 64'h01020304_05060708);
    stim[8] = 8'h09; stim[9] = 8'h0A; stim[10] = 8'h0B; stim[11] = 8'h0C;
    push_image(32'h0, 1);
    wr_count = 0;
    start_and_check("abort", 32'h0, 16'd3);
    send_bytes(6, 1'b0, edges);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check_reset_values("abort_rst");
    check("abort_writes", 32'(wr_count), 32'd1);
    check("abort_last_data", last_wr_data, 32'h0403_0201);
    check("abort_queue", 32'(exp_addr_q.size()), 32'd0);
    @(posedge clk); #1;

    set_bytes(0, 64'hAABBCCDD_00000000);
    push_image(32'h10, 1);
    wr_count = 0;
    start_and_check("reload", 32'h10, 16'd1);
    send_bytes(4, 1'b0, edges);
    finish_check("reload");
    check("reload_writes", 32'(wr_count), 32'd1);
    check("reload_addr", last_wr_addr, 32'h0000_0010);
    check("reload_data", last_wr_data, 32'hDDCC_BBAA);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Correct and wrong checksum bytes after a one-word image.
    for (int k = 0; k < 2; k++) begin
      set_bytes(0, 64'h01020304_00000000);
      push_image(32'h0, 1);
      check("csum_model", 32'(exp_sum), 32'h0A);
      start_and_check("csum", 32'h0, 16'd1);
      send_bytes(4, 1'b0, edges);
      @(negedge clk);
      check("csum_wren", 32'(mem_wren_o), 32'd1);
      @(posedge clk); #1;
      stim[0] = (k == 0) ? 8'h0A : 8'h0B;
      send_bytes(1, 1'b0, edges);
      @(negedge clk);
      check("csum_done",    32'(done_o),    32'd1);
      check("csum_err",     32'(err_o),     32'(k));
      check("csum_cpu_rst", 32'(cpu_rst_o), 32'(k));
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
`else
    // Empty image: done two cycles after start, no writes, never ready.
    no_data_check("empty", 32'h0, 16'd0);
    check("empty_cpu_rst_lit", 32'(cpu_rst_o), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("exp_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
